axi4_master_write_address: RTL and testbench

AXI4_MASTER_WRITE_ADDRESS -- requirements
Module: axi4_master_write_address

---
 rtl/axi4_pkg.sv | 19 +
 rtl/axi4_master_write_address_if.sv | 26 ++
 rtl/axi4_burst_check.sv | 43 ++++
 rtl/axi4_master_write_address.sv | 132 +++++++++++++
 tb/tb_axi4_master_write_address.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 write-address types: burst encodings, AW FSM states and the
// 4KB boundary that an INCR burst must not cross.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_VALID = 1'b1
  } aw_state_e;

  localparam int unsigned BOUNDARY_4KB = 4096;

endpackage

// File: rtl/axi4_master_write_address_if.sv
// AXI4 write-address (AW) channel bundle with master and slave views.
interface axi4_master_write_address_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int BURST_LENGTH = 8
) ();

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [BURST_LENGTH-1:0] awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready
  );

endinterface

// File: rtl/axi4_burst_check.sv
// Combinational legality check of one AW command: reserved burst, beat size
// wider than the data bus, bad WRAP/FIXED length, INCR crossing 4KB.
module axi4_burst_check
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LENGTH = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [BURST_LENGTH-1:0] len,
  input  logic [2:0]              size,
  input  logic [1:0]              burst,
  output logic                    illegal
);

  // At least 14 bits, and wide enough that a maximal len<<size never wraps.
  localparam int SUM_W = (BURST_LENGTH + 9 > 14) ? BURST_LENGTH + 9 : 14;

  logic [SUM_W-1:0] beats;
  logic [SUM_W-1:0] incr_end;
  logic [31:0]      len_32;
  logic             size_bad;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would infer a latch.
    beats    = SUM_W'(len) + SUM_W'(1);
    incr_end = SUM_W'(addr[11:0]) + (beats << size);
    len_32   = 32'(len);
    size_bad = (32'd8 << size) > 32'(DATA_WIDTH);
    illegal  = size_bad;

    case (burst_e'(burst))
      BURST_FIXED: if (len_32 > 32'd15) illegal = 1'b1;
      BURST_INCR:  if (32'(incr_end) > BOUNDARY_4KB) illegal = 1'b1;
      BURST_WRAP:  if (!(len_32 == 32'd1 || len_32 == 32'd3 ||
                         len_32 == 32'd7 || len_32 == 32'd15)) illegal = 1'b1;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_master_write_address.sv
// AXI4 AW-channel master: accepts user commands, drops illegal ones with a
// cmd_err pulse, drives registered AW signals and tracks outstanding bursts.
module axi4_master_write_address
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int BURST_LENGTH    = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [BURST_LENGTH-1:0] cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    cmd_ready,
  output logic                    cmd_err,
  input  logic                    b_done,
  output logic [3:0]              outstanding,
  axi4_master_write_address_if.master aw
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ID_WIDTH-1:0]     id;
    logic [BURST_LENGTH-1:0] len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } aw_cmd_t;

  aw_state_e  state_q, state_d;
  aw_cmd_t    cmd_q, cmd_d;
  logic       awvalid_q, awvalid_d;
  logic       cmd_err_q, cmd_err_d;
  logic [3:0] outstanding_q, outstanding_d;

  logic illegal;
  logic cmd_fire;
  logic aw_hs;
  logic retire;

  axi4_burst_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_LENGTH(BURST_LENGTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_burst_check (
    .addr   (cmd_addr),
    .len    (cmd_len),
    .size   (cmd_size),
    .burst  (cmd_burst),
    .illegal(illegal)
  );

  assign cmd_ready = (state_q == AW_IDLE) &&
                     (outstanding_q < 4'(MAX_OUTSTANDING));
  assign cmd_fire  = cmd_valid && cmd_ready;
  // awready only counts against a registered awvalid, never feeding it back.
  assign aw_hs     = awvalid_q && aw.awready;
  assign retire    = b_done && (outstanding_q != 4'd0);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    awvalid_d     = awvalid_q;
    cmd_err_d     = 1'b0;
    outstanding_d = outstanding_q;

    case (state_q)
      AW_IDLE: begin
        if (cmd_fire) begin
          cmd_d = '{addr: cmd_addr, id: cmd_id, len: cmd_len,
                    size: cmd_size, burst: cmd_burst};
          if (illegal) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d   = AW_VALID;
            awvalid_d = 1'b1;
          end
        end
      end
      AW_VALID: begin
        if (aw_hs) begin
          state_d   = AW_IDLE;
          awvalid_d = 1'b0;
        end
      end
      default: begin
        state_d   = AW_IDLE;
        awvalid_d = 1'b0;
      end
    endcase

    case ({aw_hs, retire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the AW payload is reset too, so the bus shows zeros rather than
      // X while idle and a pending command is truly discarded by reset.
      state_q       <= AW_IDLE;
      cmd_q         <= '0;
      awvalid_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      outstanding_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      awvalid_q     <= awvalid_d;
      cmd_err_q     <= cmd_err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign aw.awvalid = awvalid_q;
  assign aw.awaddr  = cmd_q.addr;
  assign aw.awid    = cmd_q.id;
  assign aw.awlen   = cmd_q.len;
  assign aw.awsize  = cmd_q.size;
  assign aw.awburst = cmd_q.burst;
  assign cmd_err     = cmd_err_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_axi4_master_write_address.sv
// Directed bench for the AXI4 AW master: issue, stall, illegal drops,
// outstanding limit and asynchronous reset mid-transaction.
module tb_axi4_master_write_address;
  import axi4_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_ready;
  logic        cmd_err;
  logic        b_done;
  logic [3:0]  outstanding;

  int checks   = 0;
  int failures = 0;

  axi4_master_write_address_if aw_if ();

  axi4_master_write_address dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_id     (cmd_id),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .cmd_ready  (cmd_ready),
    .cmd_err    (cmd_err),
    .b_done     (b_done),
    .outstanding(outstanding),
    .aw         (aw_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    cmd_addr  = addr;
    cmd_id    = id;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_b_done();
    b_done = 1'b1;
    step();
    b_done = 1'b0;
  endtask

  function automatic logic [48:0] aw_bus();
    return {aw_if.awaddr, aw_if.awid, aw_if.awlen, aw_if.awsize, aw_if.awburst};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } bad_cmd_t;

  bad_cmd_t bad_cmds [4] = '{
    '{32'h0000_0000, 8'd0,  3'd3, BURST_INCR},   // 64-bit beat on 32-bit bus
    '{32'h0000_0000, 8'd0,  3'd0, BURST_RSVD},
    '{32'h0000_0000, 8'd16, 3'd0, BURST_FIXED},
    '{32'h0000_0000, 8'd0,  3'd2, BURST_WRAP}
  };

  initial begin
    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_addr     = '0;
    cmd_id       = '0;
    cmd_len      = '0;
    cmd_size     = '0;
    cmd_burst    = '0;
    b_done       = 1'b0;
    aw_if.awready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awvalid", aw_if.awvalid, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_aw_bus", aw_bus(), 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    step();

    // Single INCR with awready tied high: one-cycle awvalid.
    aw_if.awready = 1'b1;
    send_cmd(32'h1000, 4'd1, 8'd3, 3'd2, BURST_INCR);
    check("incr_awvalid", aw_if.awvalid, 1);
    check("incr_aw_bus", aw_bus(), {32'h1000, 4'd1, 8'd3, 3'd2, 2'b01});
    check("incr_cmd_err", cmd_err, 0);
    check("incr_cmd_ready_busy", cmd_ready, 0);
    step();
    check("incr_awvalid_drop", aw_if.awvalid, 0);
    check("incr_outstanding", outstanding, 1);
    step();
    check("incr_awvalid_gap", aw_if.awvalid, 0);

    // Stall five cycles, handshake on the sixth.
    aw_if.awready = 1'b0;
    send_cmd(32'h2000, 4'd5, 8'd0, 3'd1, BURST_FIXED);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_awvalid_%0d", i), aw_if.awvalid, 1);
      check($sformatf("stall_aw_bus_%0d", i), aw_bus(),
            {32'h2000, 4'd5, 8'd0, 3'd1, 2'b00});
      check($sformatf("stall_outstanding_%0d", i), outstanding, 1);
      step();
    end
    aw_if.awready = 1'b1;
    check("stall_awvalid_6", aw_if.awvalid, 1);
    step();
    check("stall_done_awvalid", aw_if.awvalid, 0);
    check("stall_done_outstanding", outstanding, 2);

    // 0xFF0 + 8*4 = 0x1010 crosses 4KB.
    send_cmd(32'h0FF0, 4'd0, 8'd7, 3'd2, BURST_INCR);
    check("cross_cmd_err", cmd_err, 1);
    check("cross_awvalid", aw_if.awvalid, 0);
    check("cross_cmd_ready", cmd_ready, 1);
    step();
    check("cross_err_once", cmd_err, 0);
    check("cross_awvalid_low", aw_if.awvalid, 0);
    check("cross_outstanding", outstanding, 2);

    // 0xFE0 + 32 = 0x1000 ends exactly on the boundary: legal.
    send_cmd(32'h0FE0, 4'd1, 8'd7, 3'd2, BURST_INCR);
    check("edge_cmd_err", cmd_err, 0);
    check("edge_awvalid", aw_if.awvalid, 1);
    step();
    check("edge_outstanding", outstanding, 3);

    send_cmd(32'h3004, 4'd2, 8'd5, 3'd2, BURST_WRAP);
    check("wrap5_cmd_err", cmd_err, 1);
    check("wrap5_awvalid", aw_if.awvalid, 0);
    step();
    send_cmd(32'h3000, 4'd3, 8'd7, 3'd2, BURST_WRAP);
    check("wrap7_cmd_err", cmd_err, 0);
    check("wrap7_aw_bus", aw_bus(), {32'h3000, 4'd3, 8'd7, 3'd2, 2'b10});
    check("wrap7_awvalid", aw_if.awvalid, 1);
    step();
    check("wrap7_outstanding", outstanding, 4);
    check("full_cmd_ready", cmd_ready, 0);

    for (int i = 0; i < 4; i++) pulse_b_done();
    check("drain_outstanding", outstanding, 0);
    pulse_b_done();
    check("underflow_outstanding", outstanding, 0);
    check("drain_cmd_ready", cmd_ready, 1);

    foreach (bad_cmds[i]) begin
      send_cmd(bad_cmds[i].addr, 4'd0, bad_cmds[i].len, bad_cmds[i].size,
               bad_cmds[i].burst);
      check($sformatf("bad_%0d_cmd_err", i), cmd_err, 1);
      check($sformatf("bad_%0d_awvalid", i), aw_if.awvalid, 0);
      step();
    end
    send_cmd(32'h0100, 4'd4, 8'd15, 3'd2, BURST_FIXED);
    check("fixed15_awvalid", aw_if.awvalid, 1);
    step();
    check("fixed15_outstanding", outstanding, 1);
    pulse_b_done();
    check("fixed15_retired", outstanding, 0);

    // Fill to the outstanding limit.
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h4000 + 32'(i) * 32'h100, 4'(i), 8'd0, 3'd2, BURST_INCR);
      check($sformatf("fill_%0d_awvalid", i), aw_if.awvalid, 1);
      step();
    end
    check("fill_outstanding", outstanding, 4);
    check("fill_cmd_ready", cmd_ready, 0);
    cmd_addr  = 32'h4800;
    cmd_len   = 8'd0;
    cmd_size  = 3'd2;
    cmd_burst = BURST_INCR;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("blocked_awvalid", aw_if.awvalid, 0);
    check("blocked_outstanding", outstanding, 4);
    pulse_b_done();
    check("bdone_outstanding", outstanding, 3);
    check("bdone_cmd_ready", cmd_ready, 1);

    aw_if.awready = 1'b0;
    send_cmd(32'h5000, 4'd7, 8'd1, 3'd2, BURST_INCR);
    check("coincide_awvalid", aw_if.awvalid, 1);
    aw_if.awready = 1'b1;
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    aw_if.awready = 1'b0;
    check("coincide_awvalid_drop", aw_if.awvalid, 0);
    check("coincide_outstanding", outstanding, 3);

    // Asynchronous reset while a burst is stalled on awready.
    send_cmd(32'h6000, 4'd9, 8'd0, 3'd2, BURST_INCR);
    check("pre_rst_awvalid", aw_if.awvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_awvalid", aw_if.awvalid, 0);
    check("async_rst_outstanding", outstanding, 0);
    check("async_rst_aw_bus", aw_bus(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    aw_if.awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("no_replay_awvalid_%0d", i), aw_if.awvalid, 0);
      check($sformatf("no_replay_outstanding_%0d", i), outstanding, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
